// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues loads/stores on a req/ack data bus,
// stalls upstream while an access is outstanding, and owns the MEM/WB register.
module mem_stage #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  WB,
  input  logic [2:0]  M,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] ALUresult,
  input  logic [31:0] WriteData,
  input  logic [4:0]  Rd,
  input  logic [31:0] PCplus,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic [2:0]  WB_out,
  output logic [31:0] ReadData_out,
  output logic [31:0] ALUresult_out,
  output logic [31:0] PCplus_out,
  output logic [4:0]  Rd_out,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic {IDLE, REQ} state_t;

  state_t          state, state_nxt;
  logic [TO_W-1:0] cnt;
  logic            is_store, is_load, active, misalign, timeout;
  logic            issue, done, tmo;
  logic [3:0]      be_c;
  logic [31:0]     wdata_c, shifted_c, load_c;
  logic            unused_m0;

  assign unused_m0 = M[0];

  // Access decode; a store wins when both controls are set.
  assign is_store = M[1];
  assign is_load  = M[2] & ~M[1];
  assign active   = M[2] | M[1];
  assign timeout  = (cnt == CNT_LAST);

  always_comb begin
    misalign = 1'b0;
    be_c     = 4'b1111;
    wdata_c  = WriteData;
    case (mem_size)
      SZ_BYTE: begin
        be_c    = 4'b0001 << ALUresult[1:0];
        wdata_c = {4{WriteData[7:0]}};
      end
      SZ_HALF: begin
        misalign = ALUresult[0];
        be_c     = ALUresult[1] ? 4'b1100 : 4'b0011;
        wdata_c  = {2{WriteData[15:0]}};
      end
      default: misalign = (ALUresult[1:0] != 2'b00);
    endcase
  end

  // Little-endian lane extraction followed by sign/zero extension.
  assign shifted_c = dmem_rdata >> {ALUresult[1:0], 3'b000};

  always_comb begin
    load_c = shifted_c;
    case (mem_size)
      SZ_BYTE: load_c = mem_unsigned ? {24'h0, shifted_c[7:0]}
                                     : {{24{shifted_c[7]}}, shifted_c[7:0]};
      SZ_HALF: load_c = mem_unsigned ? {16'h0, shifted_c[15:0]}
                                     : {{16{shifted_c[15]}}, shifted_c[15:0]};
      default: load_c = shifted_c;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    issue     = 1'b0;
    done      = 1'b0;
    tmo       = 1'b0;
    case (state)
      IDLE: begin
        if (active && !misalign) begin
          stall     = 1'b1;
          issue     = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (dmem_ack) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (timeout) begin
          tmo       = 1'b1;
          state_nxt = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Wait counter runs only while the access stays outstanding.
  always_ff @(posedge clk) begin
    if (rst)                                    cnt <= '0;
    else if (state == REQ && state_nxt == REQ)  cnt <= cnt + TO_W'(1);
    else                                        cnt <= '0;
  end

  // Bus request and payload: captured at issue, frozen until completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= '0;
    end else if (issue) begin
      dmem_req   <= 1'b1;
      dmem_we    <= is_store;
      dmem_addr  <= {ALUresult[31:2], 2'b00};
      dmem_wdata <= wdata_c;
      dmem_be    <= be_c;
    end else if (done || tmo) begin
      dmem_req   <= 1'b0;
    end
  end

  // MEM/WB register: bubble while stalled or on error, else pass through.
  always_ff @(posedge clk) begin
    if (rst || stall || tmo || (state == IDLE && active && misalign)) begin
      WB_out        <= '0;
      ReadData_out  <= '0;
      ALUresult_out <= '0;
      PCplus_out    <= '0;
      Rd_out        <= '0;
      misalign_err  <= !rst && !stall && !tmo;
      bus_err       <= !rst && tmo;
    end else begin
      WB_out        <= WB;
      ReadData_out  <= (done && is_load) ? load_c : 32'h0;
      ALUresult_out <= ALUresult;
      PCplus_out    <= PCplus;
      Rd_out        <= Rd;
      misalign_err  <= 1'b0;
      bus_err       <= 1'b0;
    end
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline. It consumes the EX/MEM pipeline register outputs and performs loads and stores over a ready/acknowledge data-memory bus with variable latency. It holds the upstream pipeline with a stall while an access is outstanding. Its own MEM/WB pipeline register feeds the write-back stage.

## Interface
Parameters:
- TIMEOUT, 255: maximum cycles waited for dmem_ack before a bus error is declared (1..2^TO_W-1).
- TO_W, 8: width of the timeout counter.

Ports:
- clk  in  1  rising-edge clock; single clock domain. Reset is synchronous and active-high.
- rst  in  1  synchronous, active-high reset.
- WB  in  3  write-back controls from EX/MEM; passed through.
- M  in  3  memory controls: M[2]=MemRead, M[1]=MemWrite, M[0] unused here.
- mem_size  in  2  00 byte, 01 halfword, 10/11 word.
- mem_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend.
- ALUresult  in  32  effective address, or a non-memory result.
- WriteData  in  32  store data (low bits used for byte/half).
- Rd  in  5  destination register.
- PCplus  in  32  PC+4, used for link.
- dmem_req  out  1  request valid (registered).
- dmem_we  out  1  1 = store.
- dmem_addr  out  32  word-aligned address, {ALUresult[31:2],2'b00}.
- dmem_wdata  out  32  replicated store data.
- dmem_be  out  4  byte enables.
- dmem_ack  in  1  single-cycle completion strobe.
- dmem_rdata  in  32  read data, valid when dmem_ack=1.
- stall  out  1  combinational; freezes PC, IF/ID, ID/EX, EX/MEM.
- WB_out  out  3  MEM/WB register outputs.
- ReadData_out, ALUresult_out, PCplus_out  out  32
- Rd_out  out  5
- misalign_err  out  1  one-cycle pulse, registered with MEM/WB.
- bus_err  out  1  one-cycle pulse, registered with MEM/WB.

## Operation
- An access is active when M[2] or M[1] is set. If both are set, the access is a store.
- Alignment check: a half access is misaligned when addr[0]=1; a word access when addr[1:0]≠0. A misaligned access issues no bus request and no stall. MEM/WB loads a bubble (WB_out=0), and misalign_err=1 for that cycle.
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: addr[1] ? 4'b1100 : 4'b0011
  - word: 4'b1111
  - Byte order is little-endian.
- Store data: byte {4{WriteData[7:0]}}, half {2{WriteData[15:0]}}, word WriteData.
- Load data: take dmem_rdata>>(8*addr[1:0]), then sign- or zero-extend from 8 or 16 bits per mem_unsigned.
- FSM states:
  - IDLE: with an aligned active access, stall=1 and go to REQ. dmem_req/we/addr/wdata/be are registered on this edge and held constant in REQ.
  - REQ: the timeout counter increments each cycle.
    - On dmem_ack: stall=0, MEM/WB captures the result (loads get the extracted data, stores ReadData_out=0), dmem_req drops, go to IDLE.
    - When the counter reaches TIMEOUT-1 without ack: stall=0, MEM/WB loads WB_out=0 and ReadData_out=0, bus_err=1, dmem_req drops, go to IDLE.
- stall = (IDLE & active & aligned) | (REQ & ~dmem_ack & ~timeout).
- MEM/WB register:
  - When stall=0, it loads WB, ALUresult, Rd, PCplus and the load data. A non-memory instruction passes straight through with ReadData_out=0.
  - When stall=1, it loads a bubble: all fields 0.
- dmem_ack seen in IDLE is ignored.

## Timing
- A non-memory instruction has the same 1-cycle latency as a plain pipeline register.
- Memory access, ack at the first REQ cycle: instruction present at cycle N, dmem_req high at N+1, MEM/WB valid after the N+1 edge. Minimum is 2 cycles; each extra wait cycle adds one.
- Timeout: bus_err is visible TIMEOUT+1 cycles after the instruction is presented.
- Reset: state=IDLE; counter=0; dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata = 0; all MEM/WB outputs and both error flags = 0.
  - Reset mid-REQ drops dmem_req on the next edge. A late ack after reset is ignored.
- The address, data and byte-enable outputs do not change while dmem_req=1.

## Test plan
- Non-memory instruction: WB=3'b100, ALUresult=0x1234, Rd=5 → one cycle later WB_out=3'b100, ALUresult_out=0x1234, Rd_out=5, ReadData_out=0, stall never high.
- Signed byte load: addr 0x103, ack after 3 wait cycles with rdata 0x80FFFFFF → dmem_be=0001 is not expected; dmem_be=4'b1000, dmem_addr=0x100, stall high for 4 cycles, ReadData_out=0xFFFFFF80.
  - Same load with mem_unsigned=1 → ReadData_out=0x00000080.
- Halfword store: WriteData=0xAABBCCDD, addr 0x22 → dmem_we=1, dmem_be=4'b1100, dmem_wdata=0xCCDDCCDD, dmem_addr=0x20.
- Misaligned word load at 0x41 → no dmem_req, no stall, misalign_err pulse, WB_out=0.
- Timeout with TIMEOUT=4 and no ack → bus_err pulse 5 cycles after presentation, stall releases, WB_out=0, dmem_req low.
- rst asserted in the second REQ cycle → next cycle dmem_req=0, stall=0, all outputs 0; an ack arriving afterwards produces no MEM/WB update.
